// File: rtl/gf2_31_prng_ctrl.sv
// gf2_31_prng_ctrl: seedable 31-bit PRNG over GF(2)[x] / (x^31+x^13+x^8+x^3+1).
// Each step maps S -> ((x^4+1)*S + 1) mod p. Words are offered on a
// valid/ready stream, and a skip request advances the state N steps
// with no output. The status outputs are registered alongside the FSM
// state, so the flags and out_data change only on a clock edge.

// Single affine step: multiply by (x^4+1), reduce mod p, add 1.
module gf2_poly_affine_mod_31 (
    input  logic [30:0] s,
    output logic [30:0] f
);
    logic [34:0] prod_s;
    logic [30:0] red_s;

    // Carry-less multiply, then fold bits 31..34 back with x^31 == x^13+x^8+x^3+1.
    // The folded terms reach at most x^16, so one folding pass is enough.
    always_comb begin
        prod_s = {4'b0000, s} ^ {s, 4'b0000};
        red_s  = prod_s[30:0];
        for (int j = 0; j < 4; j++) begin
            if (prod_s[31 + j]) begin
                red_s = red_s ^ (31'h0000_2109 << j);
            end else begin
                red_s = red_s;
            end
        end
        f = red_s ^ 31'd1;
    end
endmodule

module gf2_31_prng_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_valid,
    input  logic [30:0] seed_data,
    output logic        seed_ready,
    input  logic        skip_valid,
    input  logic [15:0] skip_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_data,
    output logic        busy,
    output logic [31:0] out_count
);
    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_READY    = 2'd1,
        ST_SKIP     = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [30:0] s_r;
    logic [30:0] s_nxt_s;
    logic [30:0] f_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [31:0] out_count_r;
    logic [31:0] count_nxt_s;
    logic        out_valid_r;
    logic        seed_ready_r;
    logic        busy_r;
    logic        seed_acc_s;
    logic        hs_s;

    gf2_poly_affine_mod_31 u_step (
        .s (s_r),
        .f (f_s)
    );

    assign seed_acc_s = seed_valid & seed_ready_r;
    assign hs_s       = out_valid_r & out_ready;

    // Next-state, next state-word, skip counter and output counter.
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        cnt_nxt_s   = cnt_r;
        count_nxt_s = out_count_r;
        case (state_r)
            ST_UNSEEDED: begin
                if (seed_acc_s) begin
                    s_nxt_s     = seed_data;
                    count_nxt_s = 32'd0;
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_UNSEEDED;
                end
            end
            ST_READY: begin
                if (seed_acc_s) begin
                    // A coincident handshake still consumes the word, but the
                    // seed wins over F(S) and any skip request is dropped.
                    s_nxt_s     = seed_data;
                    count_nxt_s = 32'd0;
                end else begin
                    if (hs_s) begin
                        s_nxt_s     = f_s;
                        count_nxt_s = out_count_r + 32'd1;
                    end else begin
                        s_nxt_s     = s_r;
                    end
                    if (skip_valid && (skip_count != 16'd0)) begin
                        cnt_nxt_s   = skip_count;
                        state_nxt_s = ST_SKIP;
                    end else begin
                        state_nxt_s = ST_READY;
                    end
                end
            end
            ST_SKIP: begin
                s_nxt_s   = f_s;
                cnt_nxt_s = cnt_r - 16'd1;
                if (cnt_r == 16'd1) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_SKIP;
                end
            end
            default: begin
                state_nxt_s = ST_UNSEEDED;
                s_nxt_s     = 31'd0;
                cnt_nxt_s   = 16'd0;
                count_nxt_s = 32'd0;
            end
        endcase
    end

    // State, datapath and registered status flags decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_UNSEEDED;
            s_r          <= 31'd0;
            cnt_r        <= 16'd0;
            out_count_r  <= 32'd0;
            out_valid_r  <= 1'b0;
            seed_ready_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            s_r          <= s_nxt_s;
            cnt_r        <= cnt_nxt_s;
            out_count_r  <= count_nxt_s;
            out_valid_r  <= (state_nxt_s == ST_READY);
            seed_ready_r <= (state_nxt_s != ST_SKIP);
            busy_r       <= (state_nxt_s == ST_SKIP);
        end
    end

    assign seed_ready = seed_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign out_data   = s_r;
    assign out_count  = out_count_r;
endmodule

// File: tb/tb_gf2_31_prng_ctrl.sv
// Bench for gf2_31_prng_ctrl: reference model of the PRNG plus a word
// scoreboard. Expected words are queued when a handshake is driven and
// popped by a monitor when the DUT shows valid & ready.
module tb_gf2_31_prng_ctrl;
    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [30:0] seed_data;
    logic        seed_ready;
    logic        skip_valid;
    logic [15:0] skip_count;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] out_data;
    logic        busy;
    logic [31:0] out_count;

    int n_checks;
    int n_fail;
    logic [30:0] exp_q[$];

    // Reference model state.
    localparam int M_UNSEEDED = 0;
    localparam int M_READY    = 1;
    localparam int M_SKIP     = 2;
    int          m_state;
    logic [30:0] m_s;
    logic [15:0] m_cnt;
    logic [31:0] m_count;

    gf2_31_prng_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .skip_valid (skip_valid),
        .skip_count (skip_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference step: full polynomial multiply then long-division reduction.
    function automatic logic [30:0] f_model(input logic [30:0] s);
        logic [63:0] p;
        logic [63:0] poly;
        p = 64'd0;
        poly = 64'h0000_0000_8000_2109;
        for (int i = 0; i < 31; i++) begin
            if (s[i]) p = p ^ (64'h11 << i);
        end
        for (int k = 62; k >= 31; k--) begin
            if (p[k]) p = p ^ (poly << (k - 31));
        end
        p = p ^ 64'd1;
        return p[30:0];
    endfunction

    // Scoreboard monitor: every DUT handshake must match the queued word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                check_val("sb_data", {1'b0, out_data}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    // One clock cycle: drive at posedge+1, check at negedge, update model.
    task automatic step(input logic sv, input logic [30:0] sd, input logic kv,
                        input logic [15:0] kn, input logic rdy);
        seed_valid = sv;
        seed_data  = sd;
        skip_valid = kv;
        skip_count = kn;
        out_ready  = rdy;
        if (m_state == M_READY && rdy) exp_q.push_back(m_s);
        @(negedge clk);
        check_val("out_valid", {31'd0, out_valid}, {31'd0, m_state == M_READY});
        check_val("seed_ready", {31'd0, seed_ready}, {31'd0, m_state != M_SKIP});
        check_val("busy", {31'd0, busy}, {31'd0, m_state == M_SKIP});
        check_val("out_count", out_count, m_count);
        if (m_state == M_READY) check_val("out_data", {1'b0, out_data}, {1'b0, m_s});
        @(posedge clk);
        #1;
        case (m_state)
            M_UNSEEDED: begin
                if (sv) begin
                    m_s = sd; m_count = 32'd0; m_state = M_READY;
                end
            end
            M_READY: begin
                if (sv) begin
                    m_s = sd; m_count = 32'd0;
                end else begin
                    if (rdy) begin
                        m_s = f_model(m_s); m_count = m_count + 32'd1;
                    end
                    if (kv && kn != 16'd0) begin
                        m_cnt = kn; m_state = M_SKIP;
                    end
                end
            end
            default: begin
                m_s = f_model(m_s);
                if (m_cnt == 16'd1) m_state = M_READY;
                m_cnt = m_cnt - 16'd1;
            end
        endcase
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 31'd0, 1'b0, 16'd0, rdy);
    endtask

    task automatic model_reset();
        m_state = M_UNSEEDED; m_s = 31'd0; m_cnt = 16'd0; m_count = 32'd0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        seed_valid = 1'b0; seed_data = 31'd0; skip_valid = 1'b0;
        skip_count = 16'd0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        apply_reset();

        // Reference step against the known first step.
        check_val("model_f", {1'b0, f_model(31'd478163327)}, 32'd1417889173);

        // No seed, ready held high: nothing comes out.
        idle(10, 1'b1);

        // Seed then stream.
        step(1'b1, 31'd478163327, 1'b0, 16'd0, 1'b0);
        check_val("seed_word", {1'b0, out_data}, 32'd478163327);
        step(1'b0, 31'd0, 1'b0, 16'd0, 1'b1);
        check_val("stream_word1", {1'b0, out_data}, 32'd1417889173);
        check_val("stream_cnt1", out_count, 32'd1);
        step(1'b0, 31'd0, 1'b0, 16'd0, 1'b1);
        check_val("stream_cnt2", out_count, 32'd2);

        // Skip N=1 with no consumer.
        step(1'b1, 31'd478163327, 1'b0, 16'd0, 1'b0);
        step(1'b0, 31'd0, 1'b1, 16'd1, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 31'd0, 1'b0, 16'd0, 1'b0);
        check_val("skip1_word", {1'b0, out_data}, 32'd1417889173);
        check_val("skip1_cnt", out_count, 32'd0);

        // Skip N=0 is a no-op.
        step(1'b1, 31'd478163327, 1'b0, 16'd0, 1'b0);
        step(1'b0, 31'd0, 1'b1, 16'd0, 1'b0);
        idle(3, 1'b0);
        check_val("skip0_word", {1'b0, out_data}, 32'd478163327);

        // Seed 0, one handshake -> 1; then seed concurrent with handshake.
        step(1'b1, 31'd0, 1'b0, 16'd0, 1'b0);
        step(1'b0, 31'd0, 1'b0, 16'd0, 1'b1);
        check_val("zero_step", {1'b0, out_data}, 32'd1);
        step(1'b1, 31'h1234_5678, 1'b0, 16'd0, 1'b1);
        check_val("seed_hs_word", {1'b0, out_data}, 32'h1234_5678);
        check_val("seed_hs_cnt", out_count, 32'd0);

        // Seed beats skip; skip coincident with handshake.
        step(1'b1, 31'd77, 1'b1, 16'd5, 1'b1);
        step(1'b0, 31'd0, 1'b1, 16'd3, 1'b1);
        idle(5, 1'b1);

        // Long skip aborted by asynchronous reset mid-cycle.
        step(1'b1, 31'd478163327, 1'b0, 16'd0, 1'b0);
        step(1'b0, 31'd0, 1'b1, 16'd1000, 1'b0);
        idle(499, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sready", {31'd0, seed_ready}, 32'd1);
        check_val("rst_state", {1'b0, out_data}, 32'd0);
        check_val("rst_cnt", out_count, 32'd0);
        model_reset();
        seed_valid = 1'b0; skip_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 31'h2AAA_5555, 1'b0, 16'd0, 1'b0);
        idle(3, 1'b0);

        // Random stream with occasional short skips.
        for (int i = 0; i < 1000; i++) begin
            logic kv;
            kv = ($urandom_range(0, 19) == 0);
            step(1'b0, 31'd0, kv, 16'($urandom_range(0, 4)), 1'($urandom_range(0, 3) != 0));
        end
        idle(8, 1'b0);
        check_val("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end
endmodule
